// File: rtl/mppc_gate_counter.sv
// Gated dark-count counter: counts synchronized rising edges of the MPPC
// discriminator over a fixed gate, then streams a byte frame to a UART TX stage.
module mppc_gate_counter #(
  parameter int GATE_CYCLES = 100_000_000,
  parameter int COUNT_WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst_button,
  input  logic       start,
  input  logic       pulse_in,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       overflow,
  output logic [1:0] dbg_state
);

  localparam int          NB         = COUNT_WIDTH / 8;
  localparam int          LAST_IDX   = NB + 1;
  localparam logic [31:0] TIMER_LOAD = 32'(GATE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GATE = 2'd1,
    S_SEND = 2'd2
  } state_t;

  state_t                 state_q;
  logic [COUNT_WIDTH-1:0] count_q;
  logic [31:0]            timer_q;
  logic [2:0]             idx_q;
  logic                   ovf_q;
  logic [7:0]             tx_data_q;
  logic                   tx_valid_q;
  logic                   busy_q;
  logic                   sync1_q, sync2_q, sync3_q;
  logic                   pulse_edge;
  logic [2:0]             next_idx;

  always_ff @(posedge clk or negedge rst_button) begin
    if (!rst_button) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= pulse_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign pulse_edge = sync2_q & ~sync3_q;
  assign next_idx   = idx_q + 3'd1;

  // Frame order: header, counter bytes MSB first, then status.
  function automatic logic [7:0] frame_byte(input logic [2:0] idx,
                                            input logic [COUNT_WIDTH-1:0] cnt,
                                            input logic ovf);
    logic [7:0] b;
    b = 8'h00;
    if (idx == 3'd0) begin
      b = 8'hA5;
    end else if (idx == 3'(LAST_IDX)) begin
      b = {7'b0, ovf};
    end else begin
      for (int j = 1; j <= NB; j++) begin
        if (idx == 3'(j)) b = cnt[(NB - j)*8 +: 8];
      end
    end
    return b;
  endfunction

  // Handshake: in SEND tx_valid stays high and tx_data stays stable until a
  // rising edge sees tx_valid && tx_ready; only that transfer advances idx_q.
  always_ff @(posedge clk or negedge rst_button) begin
    if (!rst_button) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      timer_q    <= '0;
      idx_q      <= '0;
      ovf_q      <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            timer_q <= TIMER_LOAD;
            busy_q  <= 1'b1;
            state_q <= S_GATE;
          end
        end
        S_GATE: begin
          if (pulse_edge) begin
            if (&count_q) ovf_q <= 1'b1;
            else          count_q <= count_q + COUNT_WIDTH'(1);
          end
          if (timer_q == 32'd0) begin
            idx_q      <= 3'd0;
            tx_data_q  <= 8'hA5;
            tx_valid_q <= 1'b1;
            state_q    <= S_SEND;
          end else begin
            timer_q <= timer_q - 32'd1;
          end
        end
        S_SEND: begin
          if (tx_ready) begin
            if (idx_q == 3'(LAST_IDX)) begin
              tx_valid_q <= 1'b0;
              tx_data_q  <= 8'h00;
              busy_q     <= 1'b0;
              state_q    <= S_IDLE;
            end else begin
              idx_q     <= next_idx;
              tx_data_q <= frame_byte(next_idx, count_q, ovf_q);
            end
          end
        end
        default: begin
          tx_valid_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign busy      = busy_q;
  assign overflow  = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mppc_gate_counter.sv
// Directed bench for mppc_gate_counter: a 16-bit/1000-cycle instance and an
// 8-bit/2000-cycle instance share clock, reset, pulse and ready inputs.
module tb_mppc_gate_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_button, start16, start8, pulse_in, tx_ready;
  logic [7:0] tx_data16, tx_data8;
  logic       tx_valid16, tx_valid8, busy16, busy8, overflow16, overflow8;
  logic [1:0] dbg16, dbg8;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic       busy_before, busy_at_start, busy_last, busy_after, ovf_after;
  int         lat;

  mppc_gate_counter #(.GATE_CYCLES(1000), .COUNT_WIDTH(16)) u_dut16 (
    .clk(clk), .rst_button(rst_button), .start(start16), .pulse_in(pulse_in),
    .tx_data(tx_data16), .tx_valid(tx_valid16), .tx_ready(tx_ready),
    .busy(busy16), .overflow(overflow16), .dbg_state(dbg16)
  );

  mppc_gate_counter #(.GATE_CYCLES(2000), .COUNT_WIDTH(8)) u_dut8 (
    .clk(clk), .rst_button(rst_button), .start(start8), .pulse_in(pulse_in),
    .tx_data(tx_data8), .tx_valid(tx_valid8), .tx_ready(tx_ready),
    .busy(busy8), .overflow(overflow8), .dbg_state(dbg8)
  );

  // r counts negedges relative to the start edge N: the negedge at r precedes edge N+r.
  // Each offset o makes pulse_in high for the samples at edges N+o and N+o+1.
  task automatic gate_run(input bit sel8, input int g, input int offs[$]);
    for (int r = -4; r <= g; r++) begin
      @(negedge clk);
      if (r == 0) busy_before   = sel8 ? busy8 : busy16;
      if (r == 1) busy_at_start = sel8 ? busy8 : busy16;
      pulse_in = 1'b0;
      foreach (offs[i]) if (r == offs[i] || r == offs[i] + 1) pulse_in = 1'b1;
      start16 = (!sel8 && r == 0);
      start8  = (sel8 && r == 0);
    end
  endtask

  task automatic collect_frame(input bit sel8, input int nbytes);
    int waited;
    waited = 0;
    lat = 0;
    got_q.delete();
    while (got_q.size() < nbytes && waited < 5000) begin
      @(negedge clk);
      pulse_in = 1'b0;
      waited++;
      if (sel8 ? tx_valid8 : tx_valid16) begin
        if (lat == 0) lat = waited;
        if (tx_ready) begin
          got_q.push_back(sel8 ? tx_data8 : tx_data16);
          busy_last = sel8 ? busy8 : busy16;
        end
      end
    end
    @(negedge clk);
    busy_after = sel8 ? busy8 : busy16;
    ovf_after  = sel8 ? overflow8 : overflow16;
  endtask

  task automatic test_reset();
    int bad;
    bad = 0;
    rst_button = 1'b0; start16 = 1'b0; start8 = 1'b0; pulse_in = 1'b0; tx_ready = 1'b1;
    #3;
    vectors++; if (tx_data16 !== 8'h00) begin miscompares++; $display("FAIL rst_tx_data16 got %h want 00", tx_data16); end
    vectors++; if (tx_valid16 !== 1'b0) begin miscompares++; $display("FAIL rst_tx_valid16 got %b want 0", tx_valid16); end
    vectors++; if (busy16 !== 1'b0) begin miscompares++; $display("FAIL rst_busy16 got %b want 0", busy16); end
    vectors++; if (overflow16 !== 1'b0) begin miscompares++; $display("FAIL rst_overflow16 got %b want 0", overflow16); end
    vectors++; if (dbg16 !== 2'd0) begin miscompares++; $display("FAIL rst_state16 got %0d want 0", dbg16); end
    vectors++; if ({tx_data8, tx_valid8, busy8, overflow8} !== 11'd0) begin
      miscompares++; $display("FAIL rst_outputs8 got %h want 000", {tx_data8, tx_valid8, busy8, overflow8});
    end
    repeat (3) @(negedge clk);
    rst_button = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      pulse_in = ((i % 6) < 2);
      if (busy16 || busy8 || tx_valid16 || tx_valid8) bad++;
    end
    @(negedge clk);
    pulse_in = 1'b0;
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL idle_quiet got %0d active cycles want 0", bad); end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_basic_frame();
    int offs[$];
    logic [7:0] e;
    for (int i = 0; i < 37; i++) offs.push_back(10 + 6*i);
    tx_ready = 1'b1;
    gate_run(1'b0, 1000, offs);
    collect_frame(1'b0, 4);
    vectors++; if (busy_before !== 1'b0) begin miscompares++; $display("FAIL basic_busy_before got %b want 0", busy_before); end
    vectors++; if (busy_at_start !== 1'b1) begin miscompares++; $display("FAIL basic_busy_start got %b want 1", busy_at_start); end
    vectors++; if (lat !== 1) begin miscompares++; $display("FAIL basic_valid_latency got %0d want 1", lat); end
    exp_q.push_back(8'hA5); exp_q.push_back(8'h00); exp_q.push_back(8'h25); exp_q.push_back(8'h00);
    vectors++; if (got_q.size() !== 4) begin miscompares++; $display("FAIL basic_frame_len got %0d want 4", got_q.size()); end
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      vectors++;
      if (i >= got_q.size() || got_q[i] !== e) begin
        miscompares++; $display("FAIL basic_byte%0d got %h want %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, e);
      end
    end
    vectors++; if (busy_last !== 1'b1) begin miscompares++; $display("FAIL basic_busy_last got %b want 1", busy_last); end
    vectors++; if (busy_after !== 1'b0) begin miscompares++; $display("FAIL basic_busy_after got %b want 0", busy_after); end
    vectors++; if (ovf_after !== 1'b0) begin miscompares++; $display("FAIL basic_overflow got %b want 0", ovf_after); end
  endtask

  task automatic test_overflow();
    int offs[$];
    logic [7:0] e;
    for (int i = 0; i < 300; i++) offs.push_back(10 + 6*i);
    tx_ready = 1'b1;
    gate_run(1'b1, 2000, offs);
    collect_frame(1'b1, 3);
    vectors++; if (lat !== 1) begin miscompares++; $display("FAIL ovf_valid_latency got %0d want 1", lat); end
    exp_q.push_back(8'hA5); exp_q.push_back(8'hFF); exp_q.push_back(8'h01);
    vectors++; if (got_q.size() !== 3) begin miscompares++; $display("FAIL ovf_frame_len got %0d want 3", got_q.size()); end
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      vectors++;
      if (i >= got_q.size() || got_q[i] !== e) begin
        miscompares++; $display("FAIL ovf_byte%0d got %h want %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, e);
      end
    end
    vectors++; if (ovf_after !== 1'b1) begin miscompares++; $display("FAIL ovf_flag got %b want 1", ovf_after); end
    vectors++; if (busy_after !== 1'b0) begin miscompares++; $display("FAIL ovf_busy_after got %b want 0", busy_after); end
  endtask

  task automatic test_backpressure();
    int offs[$];
    int bad;
    logic [7:0] e;
    offs = '{10, 20, 30, 40, 50};
    bad = 0;
    tx_ready = 1'b0;
    gate_run(1'b0, 1000, offs);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      pulse_in = 1'b0;
      start16 = (i == 10);
      if (tx_valid16 !== 1'b1 || tx_data16 !== 8'hA5) bad++;
    end
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL hold_header got %0d unstable cycles want 0", bad); end
    @(negedge clk);
    vectors++; if (tx_data16 !== 8'hA5) begin miscompares++; $display("FAIL hold_release_hdr got %h want a5", tx_data16); end
    tx_ready = 1'b1;
    exp_q.push_back(8'h00); exp_q.push_back(8'h05); exp_q.push_back(8'h00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if (tx_valid16 !== 1'b1 || tx_data16 !== e) begin
        miscompares++; $display("FAIL hold_byte%0d got v=%b d=%h want v=1 d=%h", i + 1, tx_valid16, tx_data16, e);
      end
    end
    @(negedge clk);
    vectors++; if (busy16 !== 1'b0 || tx_valid16 !== 1'b0) begin
      miscompares++; $display("FAIL hold_done got busy=%b v=%b want 0 0", busy16, tx_valid16);
    end
    bad = 0;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      if (busy16 || tx_valid16) bad++;
    end
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL start_in_send got %0d busy cycles want 0", bad); end
  endtask

  task automatic test_async_reset();
    int offs[$];
    int bad;
    logic [7:0] e;
    tx_ready = 1'b1;
    @(negedge clk); start16 = 1'b1;
    @(negedge clk); start16 = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      pulse_in = ((i % 6) < 2);
    end
    vectors++; if (busy16 !== 1'b1) begin miscompares++; $display("FAIL midgate_busy got %b want 1", busy16); end
    #2 rst_button = 1'b0;
    #1;
    vectors++; if ({busy16, tx_valid16, overflow16, tx_data16, dbg16} !== 13'd0) begin
      miscompares++; $display("FAIL midgate_reset got %h want 0000", {busy16, tx_valid16, overflow16, tx_data16, dbg16});
    end
    @(negedge clk); rst_button = 1'b1; pulse_in = 1'b0;
    repeat (4) @(negedge clk);

    tx_ready = 1'b0;
    offs = '{10, 20, 30};
    gate_run(1'b0, 1000, offs);
    @(negedge clk); pulse_in = 1'b0;
    vectors++; if (tx_valid16 !== 1'b1 || tx_data16 !== 8'hA5) begin
      miscompares++; $display("FAIL midframe_hdr got v=%b d=%h want v=1 d=a5", tx_valid16, tx_data16);
    end
    tx_ready = 1'b1;
    @(negedge clk); tx_ready = 1'b0;
    vectors++; if (tx_valid16 !== 1'b1 || tx_data16 !== 8'h00) begin
      miscompares++; $display("FAIL midframe_msb got v=%b d=%h want v=1 d=00", tx_valid16, tx_data16);
    end
    #2 rst_button = 1'b0;
    #1;
    vectors++; if ({busy16, tx_valid16, overflow16, tx_data16, dbg16} !== 13'd0) begin
      miscompares++; $display("FAIL midframe_reset got %h want 0000", {busy16, tx_valid16, overflow16, tx_data16, dbg16});
    end
    @(negedge clk); rst_button = 1'b1; tx_ready = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tx_valid16 || busy16) bad++;
    end
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL frame_not_resumed got %0d active cycles want 0", bad); end

    offs = '{10, 20, 30, 40};
    gate_run(1'b0, 1000, offs);
    collect_frame(1'b0, 4);
    exp_q.push_back(8'hA5); exp_q.push_back(8'h00); exp_q.push_back(8'h04); exp_q.push_back(8'h00);
    vectors++; if (got_q.size() !== 4) begin miscompares++; $display("FAIL rst_frame_len got %0d want 4", got_q.size()); end
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      vectors++;
      if (i >= got_q.size() || got_q[i] !== e) begin
        miscompares++; $display("FAIL rst_frame_byte%0d got %h want %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, e);
      end
    end
  endtask

  task automatic test_gate_boundaries();
    int offs[$];
    logic [7:0] e;
    tx_ready = 1'b1;
    // Before-start pulse dropped, pulse whose strobe hits the last gate cycle counted.
    offs = '{-2, 998};
    gate_run(1'b0, 1000, offs);
    collect_frame(1'b0, 4);
    exp_q.push_back(8'hA5); exp_q.push_back(8'h00); exp_q.push_back(8'h01); exp_q.push_back(8'h00);
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      vectors++;
      if (i >= got_q.size() || got_q[i] !== e) begin
        miscompares++; $display("FAIL bound_a_byte%0d got %h want %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, e);
      end
    end
    repeat (4) @(negedge clk);
    // Strobe in the first gate cycle counted, strobe just after the gate dropped.
    offs = '{-1, 999};
    gate_run(1'b0, 1000, offs);
    collect_frame(1'b0, 4);
    exp_q.push_back(8'hA5); exp_q.push_back(8'h00); exp_q.push_back(8'h01); exp_q.push_back(8'h00);
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      vectors++;
      if (i >= got_q.size() || got_q[i] !== e) begin
        miscompares++; $display("FAIL bound_b_byte%0d got %h want %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_overflow();
    test_backpressure();
    test_async_reset();
    test_gate_boundaries();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mppc_gate_counter.md
# mppc_gate_counter

Gated dark-count counter for the MPPC dark-counter UART design. It sits between the MPPC discriminator output and the UART transmitter. On a start request it counts rising edges of the discriminator pulse over a fixed gate window, then streams the result as a byte frame to the UART TX stage. Overflow is detected and reported instead of wrapping.

## Interface
- `GATE_CYCLES`, default 100_000_000: gate length in `clk` cycles (1 s at 100 MHz); must be ≥ 1.
- `COUNT_WIDTH`, default 32: counter width; must be a multiple of 8, range 8..32.
- `clk` in 1: system clock, all logic on rising edge.
- `rst_button` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle start request, already debounced and synchronous to `clk`.
- `pulse_in` in 1: discriminator output, asynchronous to `clk`, high pulses ≥ 2 `clk` periods wide and ≥ 2 periods apart.
- `tx_data` out 8: byte to transmit.
- `tx_valid` out 1: `tx_data` is valid.
- `tx_ready` in 1: UART TX accepts the byte; transfer occurs when `tx_valid && tx_ready` are high on the same rising edge.
- `busy` out 1: high in GATE and SEND.
- `overflow` out 1: sticky overflow flag for the current/last measurement.

## Operation
- `pulse_in` passes through a 2-FF synchronizer, then a rising-edge detector on the synchronized signal. This gives a one-cycle `edge` strobe.
- FSM states: IDLE, GATE, SEND.
- **IDLE:**
  - On `start`: clear the counter and `overflow`, load the gate timer with `GATE_CYCLES-1`, and go to GATE.
  - An `edge` in IDLE is ignored.
- **GATE:**
  - Each `edge` increments the counter.
  - If the counter equals all-ones when an `edge` arrives, it stays all-ones and `overflow` sets. Saturate, never wrap.
  - The timer decrements each cycle. The cycle the timer reads 0 is the last gate cycle; an `edge` in that cycle is counted. The next state is SEND with a byte index of 0.
- **SEND:** emits a frame of `COUNT_WIDTH/8 + 2` bytes, in this order:
  - Header `8'hA5`.
  - Counter bytes, MSB byte first.
  - Status byte `{7'b0, overflow}`.
- Handshake rules in SEND:
  - `tx_valid` is high throughout SEND.
  - `tx_data` is stable until accepted.
  - The index advances only on a transfer.
  - After the status byte transfers, go to IDLE.
  - `tx_valid` never deasserts without a transfer.
- `start` is ignored when the state is not IDLE.
- A `start` on the same cycle as the final transfer is also ignored. The next start is honored from IDLE onward.
- The counter and `overflow` hold their final values in IDLE until the next `start`.
- Reset (asynchronous assert, at any time including mid-gate or mid-frame) has the following effect:
  - State goes to IDLE.
  - Counter, timer, index and synchronizer flops clear to 0.
  - The frame is abandoned and not resumed.

## Timing
- Reset values: `tx_data`=0, `tx_valid`=0, `busy`=0, `overflow`=0.
- `start` sampled high at edge N: `busy`=1 from edge N. The gate covers the cycles after edges N..N+GATE_CYCLES-1, exactly `GATE_CYCLES` cycles.
- `pulse_in` rising to `edge` strobe latency: 3 `clk` edges. A pulse rising fewer than 3 cycles before the gate closes is not counted. Edges detected during IDLE/SEND are dropped.
- `tx_valid` rises on edge N+GATE_CYCLES. The header is presented in that cycle.
- With `tx_ready` held high: one byte per cycle. The frame completes `COUNT_WIDTH/8+2` cycles after SEND entry, and `busy`=0 on the following cycle.
- `tx_ready` low: the byte holds indefinitely, with no timeout.

## Test plan
1. Reset deasserted, no start, `pulse_in` toggling: `busy`=0, `tx_valid`=0, no bytes emitted.
2. `GATE_CYCLES`=1000, `COUNT_WIDTH`=16, `tx_ready`=1, 37 pulses inside the gate. Required frame: A5, 00, 25, 00; `overflow`=0; `busy` low 4 cycles after the gate ends.
3. `COUNT_WIDTH`=8, `GATE_CYCLES`=2000, 300 pulses (period 6 cycles). Required frame: A5, FF, 01; `overflow`=1.
4. `tx_ready` held low 50 cycles after header presentation, then released. A5 stays stable the whole time, then the remaining bytes follow one per cycle. A `start` pulsed during SEND is ignored, with no second frame.
5. `rst_button` pulled low mid-gate and then mid-frame. All outputs go to 0 immediately and asynchronously. After release plus a new `start`, the counter restarts at 0 and emits a fresh correct frame.
6. Pulses at gate boundaries: a pulse rising 2 cycles before `start` is not counted; a pulse whose edge strobe lands exactly on the last gate cycle is counted.
